// File: rtl/page_walker_if.sv
// ============================================================================
//  Module   : page_walker_if
//  Brief    : Miss-request, fill-response and table-write bundle for the
//             page walker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface page_walker_if;
  logic       miss_valid;
  logic       miss_ready;
  logic       miss_spec;
  logic [4:0] miss_vpn;

  logic       fill_valid;
  logic       fill_ready;
  logic       fill_hit;
  logic       fill_spec;
  logic [4:0] fill_vpn;
  logic [4:0] fill_ppn;
  logic [5:0] probe_cnt;

  logic        pt_wr_en;
  logic        pt_wr_sel;
  logic [4:0]  pt_wr_idx;
  logic [10:0] pt_wr_data;

  modport master (
    output miss_valid, miss_spec, miss_vpn, fill_ready,
    output pt_wr_en, pt_wr_sel, pt_wr_idx, pt_wr_data,
    input  miss_ready, fill_valid, fill_hit, fill_spec, fill_vpn, fill_ppn, probe_cnt
  );

  modport slave (
    input  miss_valid, miss_spec, miss_vpn, fill_ready,
    input  pt_wr_en, pt_wr_sel, pt_wr_idx, pt_wr_data,
    output miss_ready, fill_valid, fill_hit, fill_spec, fill_vpn, fill_ppn, probe_cnt
  );
endinterface

`default_nettype wire

// File: rtl/page_walker.sv
// ============================================================================
//  Module   : page_walker
//  Brief    : Sequential page-table walker over an 8B and a 32B table.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module page_walker #(
  parameter int PT8_ENTRIES  = 32,
  parameter int PT32_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  page_walker_if.slave bus
);

  localparam int         IDX8_W  = $clog2(PT8_ENTRIES);
  localparam int         IDX32_W = $clog2(PT32_ENTRIES);
  localparam logic [4:0] LAST8   = 5'(PT8_ENTRIES - 1);
  localparam logic [4:0] LAST32  = 5'(PT32_ENTRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [5:0] probe_cnt_q, probe_cnt_d;
  logic       spec_q, spec_d;
  logic [4:0] vpn_q, vpn_d;
  logic       hit_q, hit_d;
  logic [4:0] ppn_q, ppn_d;

  // Valid bits need reset; tag/PPN storage does not.
  logic [PT8_ENTRIES-1:0]  pt8_valid_q;
  logic [4:0]              pt8_tag_q [PT8_ENTRIES];
  logic [4:0]              pt8_ppn_q [PT8_ENTRIES];
  logic [PT32_ENTRIES-1:0] pt32_valid_q;
  logic [2:0]              pt32_tag_q [PT32_ENTRIES];
  logic [2:0]              pt32_ppn_q [PT32_ENTRIES];

  logic               wr_en8, wr_en32;
  logic [IDX8_W-1:0]  wr_idx8, probe_idx8;
  logic [IDX32_W-1:0] wr_idx32, probe_idx32;
  logic               hit8, hit32, probe_hit, at_last;
  logic [4:0]         probe_ppn;

  assign wr_en8   = bus.pt_wr_en && !bus.pt_wr_sel;
  assign wr_en32  = bus.pt_wr_en && bus.pt_wr_sel && (bus.pt_wr_idx <= LAST32);
  assign wr_idx8  = bus.pt_wr_idx[IDX8_W-1:0];
  assign wr_idx32 = bus.pt_wr_idx[IDX32_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt8_valid_q  <= '0;
      pt32_valid_q <= '0;
    end else begin
      if (wr_en8)  pt8_valid_q[wr_idx8]   <= bus.pt_wr_data[10];
      if (wr_en32) pt32_valid_q[wr_idx32] <= bus.pt_wr_data[10];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en8) begin
      pt8_tag_q[wr_idx8] <= bus.pt_wr_data[9:5];
      pt8_ppn_q[wr_idx8] <= bus.pt_wr_data[4:0];
    end
    if (wr_en32) begin
      pt32_tag_q[wr_idx32] <= bus.pt_wr_data[7:5];
      pt32_ppn_q[wr_idx32] <= bus.pt_wr_data[2:0];
    end
  end

  // Probe reads registered storage, so a same-cycle write is seen only next cycle.
  assign probe_idx8  = idx_q[IDX8_W-1:0];
  assign probe_idx32 = idx_q[IDX32_W-1:0];
  assign hit8        = pt8_valid_q[probe_idx8] && (pt8_tag_q[probe_idx8] == vpn_q);
  assign hit32       = pt32_valid_q[probe_idx32] && (pt32_tag_q[probe_idx32] == vpn_q[2:0]);
  assign probe_hit   = spec_q ? hit32 : hit8;
  assign probe_ppn   = spec_q ? {2'b00, pt32_ppn_q[probe_idx32]} : pt8_ppn_q[probe_idx8];
  assign at_last     = (idx_q == (spec_q ? LAST32 : LAST8));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      probe_cnt_q <= '0;
      spec_q      <= 1'b0;
      vpn_q       <= '0;
      hit_q       <= 1'b0;
      ppn_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      probe_cnt_q <= probe_cnt_d;
      spec_q      <= spec_d;
      vpn_q       <= vpn_d;
      hit_q       <= hit_d;
      ppn_q       <= ppn_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    probe_cnt_d = probe_cnt_q;
    spec_d      = spec_q;
    vpn_d       = vpn_q;
    hit_d       = hit_q;
    ppn_d       = ppn_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.miss_valid) begin
          state_d     = S_WALK;
          idx_d       = '0;
          probe_cnt_d = '0;
          spec_d      = bus.miss_spec;
          vpn_d       = bus.miss_spec ? {2'b00, bus.miss_vpn[2:0]} : bus.miss_vpn;
        end
      end
      S_WALK: begin
        probe_cnt_d = probe_cnt_q + 6'd1;
        if (probe_hit) begin
          hit_d   = 1'b1;
          ppn_d   = probe_ppn;
          state_d = S_RESP;
        end else if (at_last) begin
          hit_d   = 1'b0;
          ppn_d   = '0;
          state_d = S_RESP;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_RESP: begin
        if (bus.fill_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.miss_ready = (state_q == S_IDLE);
  assign bus.fill_valid = (state_q == S_RESP);
  assign bus.fill_hit   = hit_q;
  assign bus.fill_spec  = spec_q;
  assign bus.fill_vpn   = vpn_q;
  assign bus.fill_ppn   = ppn_q;
  assign bus.probe_cnt  = probe_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_page_walker.sv
// ============================================================================
//  Module   : tb_page_walker
//  Brief    : Directed self-checking bench for page_walker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_page_walker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  page_walker_if bus ();

  page_walker #(.PT8_ENTRIES(32), .PT32_ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic pt_write(input logic sel, input logic [4:0] idx, input logic [10:0] data);
    bus.pt_wr_en   = 1'b1;
    bus.pt_wr_sel  = sel;
    bus.pt_wr_idx  = idx;
    bus.pt_wr_data = data;
    @(negedge clk);
    bus.pt_wr_en   = 1'b0;
  endtask

  // Called at a negedge; returns at the first negedge where FILL_VALID is high.
  task automatic issue(input logic spec, input logic [4:0] vpn, output int lat);
    bus.miss_valid = 1'b1;
    bus.miss_spec  = spec;
    bus.miss_vpn   = vpn;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    lat = 0;
    while (bus.fill_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    bus.fill_ready = 1'b1;
    @(negedge clk);
    bus.fill_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready act=%0h exp=1", bus.miss_ready); end
    checks++; if (bus.fill_valid !== 1'b0) begin errors++; $display("FAIL reset_fill_valid act=%0h exp=0", bus.fill_valid); end
    checks++; if (bus.fill_hit !== 1'b0) begin errors++; $display("FAIL reset_hit act=%0h exp=0", bus.fill_hit); end
    checks++; if (bus.fill_spec !== 1'b0) begin errors++; $display("FAIL reset_spec act=%0h exp=0", bus.fill_spec); end
    checks++; if (bus.fill_vpn !== 5'h00) begin errors++; $display("FAIL reset_vpn act=%0h exp=0", bus.fill_vpn); end
    checks++; if (bus.fill_ppn !== 5'h00) begin errors++; $display("FAIL reset_ppn act=%0h exp=0", bus.fill_ppn); end
    checks++; if (bus.probe_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt act=%0d exp=0", bus.probe_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_8b_miss();
    int lat;
    issue(1'b0, 5'h02, lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL miss8_latency act=%0d exp=32", lat); end
    checks++; if (bus.fill_hit !== 1'b0) begin errors++; $display("FAIL miss8_hit act=%0h exp=0", bus.fill_hit); end
    checks++; if (bus.fill_ppn !== 5'h00) begin errors++; $display("FAIL miss8_ppn act=%0h exp=0", bus.fill_ppn); end
    checks++; if (bus.probe_cnt !== 6'd32) begin errors++; $display("FAIL miss8_cnt act=%0d exp=32", bus.probe_cnt); end
    checks++; if (bus.fill_vpn !== 5'h02) begin errors++; $display("FAIL miss8_vpn act=%0h exp=02", bus.fill_vpn); end
    handshake();
    checks++; if (bus.fill_valid !== 1'b0) begin errors++; $display("FAIL miss8_release act=%0h exp=0", bus.fill_valid); end
  endtask

  task automatic test_8b_hit();
    int lat;
    pt_write(1'b0, 5'd3, {1'b1, 5'h1A, 5'h07});
    issue(1'b0, 5'h1A, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL hit8_latency act=%0d exp=4", lat); end
    checks++; if (bus.fill_hit !== 1'b1) begin errors++; $display("FAIL hit8_hit act=%0h exp=1", bus.fill_hit); end
    checks++; if (bus.fill_ppn !== 5'h07) begin errors++; $display("FAIL hit8_ppn act=%0h exp=07", bus.fill_ppn); end
    checks++; if (bus.probe_cnt !== 6'd4) begin errors++; $display("FAIL hit8_cnt act=%0d exp=4", bus.probe_cnt); end
    checks++; if (bus.fill_spec !== 1'b0) begin errors++; $display("FAIL hit8_spec act=%0h exp=0", bus.fill_spec); end
    checks++; if (bus.fill_vpn !== 5'h1A) begin errors++; $display("FAIL hit8_vpn act=%0h exp=1a", bus.fill_vpn); end
    handshake();
    checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL hit8_idle act=%0h exp=1", bus.miss_ready); end
  endtask

  task automatic test_32b_hit();
    int lat;
    pt_write(1'b1, 5'd15, {1'b1, 2'b00, 3'b101, 2'b00, 3'b110});
    issue(1'b1, 5'h1D, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL hit32_latency act=%0d exp=16", lat); end
    checks++; if (bus.fill_hit !== 1'b1) begin errors++; $display("FAIL hit32_hit act=%0h exp=1", bus.fill_hit); end
    checks++; if (bus.fill_vpn !== 5'h05) begin errors++; $display("FAIL hit32_vpn act=%0h exp=05", bus.fill_vpn); end
    checks++; if (bus.fill_ppn !== 5'h06) begin errors++; $display("FAIL hit32_ppn act=%0h exp=06", bus.fill_ppn); end
    checks++; if (bus.probe_cnt !== 6'd16) begin errors++; $display("FAIL hit32_cnt act=%0d exp=16", bus.probe_cnt); end
    checks++; if (bus.fill_spec !== 1'b1) begin errors++; $display("FAIL hit32_spec act=%0h exp=1", bus.fill_spec); end
    handshake();
  endtask

  task automatic test_duplicate_hold();
    int lat;
    pt_write(1'b0, 5'd2, {1'b1, 5'h04, 5'h01});
    pt_write(1'b0, 5'd9, {1'b1, 5'h04, 5'h02});
    issue(1'b0, 5'h04, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL dup_latency act=%0d exp=3", lat); end
    checks++; if (bus.fill_ppn !== 5'h01) begin errors++; $display("FAIL dup_ppn act=%0h exp=01", bus.fill_ppn); end
    // Stall the response while a new request and a table write arrive.
    bus.miss_valid = 1'b1;
    bus.miss_spec  = 1'b0;
    bus.miss_vpn   = 5'h1A;
    bus.pt_wr_en   = 1'b1;
    bus.pt_wr_sel  = 1'b0;
    bus.pt_wr_idx  = 5'd2;
    bus.pt_wr_data = 11'h000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.pt_wr_en = 1'b0;
      checks++; if (bus.fill_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] act=%0h exp=1", i, bus.fill_valid); end
      checks++; if (bus.fill_hit !== 1'b1) begin errors++; $display("FAIL hold_hit[%0d] act=%0h exp=1", i, bus.fill_hit); end
      checks++; if (bus.fill_ppn !== 5'h01) begin errors++; $display("FAIL hold_ppn[%0d] act=%0h exp=01", i, bus.fill_ppn); end
      checks++; if (bus.fill_vpn !== 5'h04) begin errors++; $display("FAIL hold_vpn[%0d] act=%0h exp=04", i, bus.fill_vpn); end
      checks++; if (bus.probe_cnt !== 6'd3) begin errors++; $display("FAIL hold_cnt[%0d] act=%0d exp=3", i, bus.probe_cnt); end
      checks++; if (bus.miss_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] act=%0h exp=0", i, bus.miss_ready); end
    end
    bus.miss_valid = 1'b0;
    handshake();
    checks++; if (bus.fill_valid !== 1'b0) begin errors++; $display("FAIL dup_release act=%0h exp=0", bus.fill_valid); end
    @(negedge clk);
    checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL dup_stay_idle act=%0h exp=1", bus.miss_ready); end
  endtask

  task automatic test_reset_mid_walk();
    int lat;
    int seen;
    // Index 2 was invalidated during the hold, so this walk would match at 9.
    bus.miss_valid = 1'b1;
    bus.miss_spec  = 1'b0;
    bus.miss_vpn   = 5'h04;
    @(negedge clk);
    bus.miss_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus.probe_cnt !== 6'd5) begin errors++; $display("FAIL walk_cnt_pre act=%0d exp=5", bus.probe_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (bus.miss_ready !== 1'b1) begin errors++; $display("FAIL async_ready act=%0h exp=1", bus.miss_ready); end
    checks++; if (bus.probe_cnt !== 6'd0) begin errors++; $display("FAIL async_cnt act=%0d exp=0", bus.probe_cnt); end
    checks++; if (bus.fill_vpn !== 5'h00) begin errors++; $display("FAIL async_vpn act=%0h exp=0", bus.fill_vpn); end
    checks++; if (bus.fill_hit !== 1'b0) begin errors++; $display("FAIL async_hit act=%0h exp=0", bus.fill_hit); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.fill_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abandoned_fill act=%0d exp=0", seen); end
    issue(1'b0, 5'h04, lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL post_reset_latency act=%0d exp=32", lat); end
    checks++; if (bus.fill_hit !== 1'b0) begin errors++; $display("FAIL post_reset_hit act=%0h exp=0", bus.fill_hit); end
    checks++; if (bus.probe_cnt !== 6'd32) begin errors++; $display("FAIL post_reset_cnt act=%0d exp=32", bus.probe_cnt); end
    handshake();
  endtask

  task automatic test_write_collision();
    int lat;
    pt_write(1'b0, 5'd0, {1'b1, 5'h11, 5'h0A});
    bus.miss_valid = 1'b1;
    bus.miss_spec  = 1'b0;
    bus.miss_vpn   = 5'h11;
    @(negedge clk);
    // First probe cycle: overwrite entry 0 as invalid.
    bus.miss_valid = 1'b0;
    bus.pt_wr_en   = 1'b1;
    bus.pt_wr_sel  = 1'b0;
    bus.pt_wr_idx  = 5'd0;
    bus.pt_wr_data = 11'h000;
    @(negedge clk);
    bus.pt_wr_en   = 1'b0;
    checks++; if (bus.fill_valid !== 1'b1) begin errors++; $display("FAIL coll_valid act=%0h exp=1", bus.fill_valid); end
    checks++; if (bus.fill_hit !== 1'b1) begin errors++; $display("FAIL coll_hit act=%0h exp=1", bus.fill_hit); end
    checks++; if (bus.fill_ppn !== 5'h0A) begin errors++; $display("FAIL coll_ppn act=%0h exp=0a", bus.fill_ppn); end
    checks++; if (bus.probe_cnt !== 6'd1) begin errors++; $display("FAIL coll_cnt act=%0d exp=1", bus.probe_cnt); end
    handshake();
    @(negedge clk);
    issue(1'b0, 5'h11, lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL coll_after_latency act=%0d exp=32", lat); end
    checks++; if (bus.fill_hit !== 1'b0) begin errors++; $display("FAIL coll_after_hit act=%0h exp=0", bus.fill_hit); end
    handshake();
    pt_write(1'b1, 5'd20, {1'b1, 2'b00, 3'b101, 2'b00, 3'b011});
    issue(1'b1, 5'h05, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL wr32_oob_latency act=%0d exp=16", lat); end
    checks++; if (bus.fill_hit !== 1'b0) begin errors++; $display("FAIL wr32_oob_hit act=%0h exp=0", bus.fill_hit); end
    checks++; if (bus.fill_ppn !== 5'h00) begin errors++; $display("FAIL wr32_oob_ppn act=%0h exp=0", bus.fill_ppn); end
    handshake();
  endtask

  initial begin
    bus.miss_valid = 1'b0;
    bus.miss_spec  = 1'b0;
    bus.miss_vpn   = 5'h00;
    bus.fill_ready = 1'b0;
    bus.pt_wr_en   = 1'b0;
    bus.pt_wr_sel  = 1'b0;
    bus.pt_wr_idx  = 5'h00;
    bus.pt_wr_data = 11'h000;
    test_reset();
    test_8b_miss();
    test_8b_hit();
    test_32b_hit();
    test_duplicate_hold();
    test_reset_mid_walk();
    test_write_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire

// File: doc/page_walker.md
PAGE_WALKER -- requirements
Module: page_walker

Interface
REQ-001 Parameter PT8_ENTRIES, 32: 8B page-table depth, index 0..31.
REQ-002 Parameter PT32_ENTRIES, 16: 32B page-table depth, index 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 MISS_VALID  input  1  TLB-miss walk request valid.
REQ-006 MISS_READY  output  1  walker idle and accepting a request.
REQ-007 MISS_SPEC  input  1  table select: 0 = 8B table, 1 = 32B table.
REQ-008 MISS_VPN  input  5  virtual page number; 8B uses [4:0], 32B uses [2:0], [4:3] ignored.
REQ-009 FILL_VALID  output  1  walk result valid toward TLB refill.
REQ-010 FILL_READY  input  1  TLB accepts the result.
REQ-011 FILL_HIT  output  1  1 = translation found, 0 = page fault.
REQ-012 FILL_SPEC  output  1  echo of captured MISS_SPEC.
REQ-013 FILL_VPN  output  5  echo of captured VPN; [4:3]=0 in 32B mode.
REQ-014 FILL_PPN  output  5  physical page number; 32B: [2:0] valid, [4:3]=0; 0 on fault.
REQ-015 PROBE_CNT  output  6  entries probed by the walk being reported.
REQ-016 PT_WR_EN  input  1  table write strobe.
REQ-017 PT_WR_SEL  input  1  0 = write 8B table, 1 = write 32B table.
REQ-018 PT_WR_IDX  input  5  entry index.
REQ-019 PT_WR_DATA  input  11  [10] valid, [9:5] VPN tag, [4:0] PPN; 32B uses [10], [7:5] tag, [2:0] PPN.

Function
REQ-020 FSM states SHALL be IDLE, WALK, RESP; MISS_READY SHALL be 1 exactly in IDLE.
REQ-021 IDLE: on MISS_VALID=1, capture MISS_SPEC/MISS_VPN, clear index and PROBE_CNT, go WALK; MISS_VALID while not IDLE SHALL be ignored.
REQ-022 WALK: each cycle probe entry[index] of selected table; PROBE_CNT SHALL increment per probe.
REQ-023 Probe match = entry valid AND tag equals captured VPN (5 bits for 8B, 3 bits for 32B).
REQ-024 On match, latch FILL_PPN from entry, set FILL_HIT=1, go RESP; lowest matching index wins.
REQ-025 On no match at last index (PT8_ENTRIES-1 or PT32_ENTRIES-1), set FILL_HIT=0, FILL_PPN=0, go RESP; otherwise index increments, no wrap.
REQ-026 Latency: match at index k SHALL raise FILL_VALID k+1 cycles after the accepting edge; full miss 32 cycles (8B), 16 cycles (32B).
REQ-027 RESP: FILL_VALID=1 with FILL_* and PROBE_CNT held stable until FILL_READY=1; on that edge go IDLE, FILL_VALID=0.
REQ-028 FILL_READY outside RESP SHALL have no effect.
REQ-029 Table writes SHALL be accepted in every state; write updates entry on the rising edge.
REQ-030 Write and probe to same entry in same cycle: probe SHALL see old contents.
REQ-031 PT_WR_SEL=1 with PT_WR_IDX>=16 SHALL be ignored.
REQ-032 Writes SHALL not alter a result already held in RESP.
REQ-033 Minimum request spacing: one IDLE cycle after each fill handshake.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, MISS_READY=1, FILL_VALID=0, FILL_HIT=0, FILL_SPEC=0, FILL_VPN=0, FILL_PPN=0, PROBE_CNT=0.
REQ-035 Reset SHALL clear all valid bits in both tables; table data otherwise undefined.
REQ-036 Reset mid-WALK or mid-RESP SHALL abandon the walk with no fill produced.

Verification
REQ-037 8B write idx 3 = {1,5'h1A,5'h07}; miss VPN 5'h1A spec 0 -> FILL_VALID 4 cycles after accept, HIT=1, PPN=7, PROBE_CNT=4.
REQ-038 32B write idx 15 = tag 3'b101, PPN 3'b110; miss VPN 5'h1D spec 1 -> 16 cycles, HIT=1, FILL_VPN=5'h05, PPN=5'h06, PROBE_CNT=16.
REQ-039 Empty 8B table, miss VPN 5'h02 -> 32 cycles, HIT=0, PPN=0, PROBE_CNT=32.
REQ-040 Duplicate tag 5'h04 at idx 2 (PPN 1) and idx 9 (PPN 2) -> PPN=1; FILL_READY held 0 for 5 cycles -> outputs stable, MISS_VALID ignored, then handshake returns IDLE.
REQ-041 rst pulsed at walk probe 6 -> FILL_VALID never rises; repeat previous hit request -> HIT=0 after 32 cycles.
REQ-042 Write entry 0 invalid while probing it in same cycle after prior valid match setup -> old match reported; 32B write idx 20 -> no table change.
